// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle magnitude comparator, DIGIT bits per cycle, MSB digit first.
// Latency: NDIG = WIDTH/DIGIT cycles from the accepting start edge to done.
//   With CMP_EARLY_EXIT_EN defined, the compare ends at the first differing digit.
// Backpressure: none. start is honoured only in IDLE or DONE and is ignored while busy.
//
// Optional build macro: CMP_EARLY_EXIT_EN (leave RUN as soon as the outcome is known).
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 request a compare (sampled in IDLE/DONE)
//   a, b, signed_mode     operands and mode, captured on the accepting edge
//   busy                  high while comparing (RUN)
//   done                  one-cycle pulse, result flags valid from this cycle
//   a_grt_b/a_less_b/a_eq_b  registered result, held until the next done
//
// WIDTH must be an integer multiple of DIGIT.
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             a_grt_b,
  output logic             a_less_b,
  output logic             a_eq_b
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             dec_gt, dec_lt;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_gt, dig_lt, decided, last_dig;
  logic             accept, finish;
  logic             fin_gt, fin_lt;
  logic [WIDTH-1:0] msb_flip;

  assign dig_a    = sh_a[WIDTH-1 -: DIGIT];
  assign dig_b    = sh_b[WIDTH-1 -: DIGIT];
  assign dig_gt   = dig_a > dig_b;
  assign dig_lt   = dig_a < dig_b;
  assign decided  = dec_gt | dec_lt;
  assign last_dig = (cnt == CW'(NDIG - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // The first differing digit wins; the current digit only matters while undecided.
  assign fin_gt = dec_gt | (~decided & dig_gt);
  assign fin_lt = dec_lt | (~decided & dig_lt);

  // Flipping the sign bit maps two's complement onto offset binary, so a plain
  // unsigned digit compare then orders signed values correctly.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
`ifdef CMP_EARLY_EXIT_EN
        finish = last_dig | (~decided & (dig_gt | dig_lt));
`else
        finish = last_dig;
`endif
        if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      cnt      <= '0;
      dec_gt   <= 1'b0;
      dec_lt   <= 1'b0;
      a_grt_b  <= 1'b0;
      a_less_b <= 1'b0;
      a_eq_b   <= 1'b0;
    end else if (accept) begin
      sh_a   <= a ^ msb_flip;
      sh_b   <= b ^ msb_flip;
      cnt    <= '0;
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
    end else if (state == RUN) begin
      sh_a <= sh_a << DIGIT;
      sh_b <= sh_b << DIGIT;
      cnt  <= cnt + CW'(1);
      if (!decided) begin
        dec_gt <= dig_gt;
        dec_lt <= dig_lt;
      end
      if (finish) begin
        a_grt_b  <= fin_gt;
        a_less_b <= fin_lt;
        a_eq_b   <= ~(fin_gt | fin_lt);
      end
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
module tb_seq_comparator;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             signed_mode;
  logic             busy, done, a_grt_b, a_less_b, a_eq_b;

  // flags ordered {gt, lt, eq}
  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         fails  = 0;
  logic [2:0] prev_flags;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .a_grt_b(a_grt_b), .a_less_b(a_less_b), .a_eq_b(a_eq_b)
  );

  // Reference: native signed/unsigned compare, latency from first differing digit.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic sm);
    exp_t e;
    logic gt, lt;
    if (sm) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    e.flags = {gt, lt, ~(gt | lt)};
    e.lat   = NDIG;
`ifdef CMP_EARLY_EXIT_EN
    begin
      bit found;
      found = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
        if (!found && (x[i*DIGIT +: DIGIT] != y[i*DIGIT +: DIGIT])) begin
          found = 1'b1;
          e.lat = NDIG - i;
        end
      end
    end
`endif
    return e;
  endfunction

  // Presents a request one cycle; returns 1ns after the accepting edge with
  // the inputs scrambled to show they are no longer looked at.
  task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic sm);
    @(negedge clk);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  // Called just after edge number 'skip' following the accepting edge.
  task automatic wait_done(input string name, input int skip, input bit drop_chk);
    int   n;
    int   bc;
    bit   hold_bad;
    bit   seen;
    exp_t e;
    n = skip; bc = 0; hold_bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!seen) begin
        @(negedge clk);
        if (done) seen = 1'b1;
        else begin
          if (busy) bc++;
          if ({a_grt_b, a_less_b, a_eq_b} !== prev_flags) hold_bad = 1'b1;
          @(posedge clk);
          n++;
        end
      end
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: done=0 after %0d cycles, required a done pulse", name, n);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: done seen with empty queue, required no done", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (n !== e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
    end
    checks++;
    if (bc !== e.lat - skip) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, e.lat - skip);
    end
    checks++;
    if ({a_grt_b, a_less_b, a_eq_b} !== e.flags) begin
      fails++;
      $display("FAIL %s flags{gt,lt,eq}: got %b required %b", name,
               {a_grt_b, a_less_b, a_eq_b}, e.flags);
    end
    checks++;
    if (hold_bad !== 1'b0) begin
      fails++;
      $display("FAIL %s hold: flags changed before done, required held at %b", name, prev_flags);
    end
    prev_flags = e.flags;
    if (drop_chk) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
      end
    end
  endtask

  task automatic run_one(input string name, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic sm);
    sb.push_back(model(x, y, sm));
    drive_start(x, y, sm);
    wait_done(name, 0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, a_grt_b, a_less_b, a_eq_b} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got %b required 00000", {busy, done, a_grt_b, a_less_b, a_eq_b});
    end
    rst = 1'b0;
    prev_flags = 3'b000;
  endtask

  task automatic test_equal();
    run_one("equal", 16'h1234, 16'h1234, 1'b0);
  endtask

  task automatic test_mode();
    run_one("unsigned_8000_7fff", 16'h8000, 16'h7FFF, 1'b0);
    run_one("signed_8000_7fff",   16'h8000, 16'h7FFF, 1'b1);
    run_one("signed_ffff_fffe",   16'hFFFF, 16'hFFFE, 1'b1);
  endtask

  task automatic test_early_exit();
    run_one("early_1000_2000", 16'h1000, 16'h2000, 1'b0);
    run_one("late_1235_1234",  16'h1235, 16'h1234, 1'b0);
  endtask

  task automatic test_start_while_busy();
    bit extra;
    sb.push_back(model(16'h0005, 16'h0003, 1'b0));
    drive_start(16'h0005, 16'h0003, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 16'h0000; b = 16'h0009; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("start_while_busy", 2, 1'b1);
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      fails++;
      $display("FAIL start_while_busy second_compare: got activity=1 required 0");
    end
  endtask

  task automatic test_reset_mid_run();
    bit extra;
    drive_start(16'h4321, 16'h4320, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, a_grt_b, a_less_b, a_eq_b} !== 5'b0) begin
      fails++;
      $display("FAIL reset_mid_run outputs: got %b required 00000",
               {busy, done, a_grt_b, a_less_b, a_eq_b});
    end
    @(negedge clk);
    rst = 1'b0;
    prev_flags = 3'b000;
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run aborted: got activity=1 required 0");
    end
    run_one("after_reset_00ff", 16'h00FF, 16'h00FF, 1'b0);
  endtask

  task automatic test_back_to_back();
    sb.push_back(model(16'h0009, 16'h0003, 1'b0));
    drive_start(16'h0009, 16'h0003, 1'b0);
    wait_done("b2b_first", 0, 1'b0);
    // Still in the DONE cycle: request the next compare right away.
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    sb.push_back(model(16'h0001, 16'h0002, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b_second", 0, 1'b1);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x, y;
    logic             sm;
    for (int i = 0; i < 8; i++) begin
      x  = WIDTH'($urandom);
      y  = (i % 3 == 0) ? x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : WIDTH'($urandom);
      sm = 1'($urandom_range(0, 1));
      run_one("random", x, y, sm);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_mode();
    test_early_exit();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
